// File: rtl/ghash_pkg.sv
// Shared constants, FSM encoding and length-block helper for the GHASH feed path.
// Used by both the encrypt-side packer and the decrypt path.
package ghash_pkg;

    localparam int NB_BLOCK = 128;
    localparam int N_BLOCKS = 2;
    localparam int NB_DATA  = N_BLOCKS * NB_BLOCK;
    localparam int NB_LEN   = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LENGTH  = 2'd2
    } state_t;

    localparam logic [N_BLOCKS-1:0] SKIP_NONE  = 2'b00;
    localparam logic [N_BLOCKS-1:0] SKIP_LANE1 = 2'b10;

    // GCM final block: len(A) in the upper half, len(C) in the lower half.
    function automatic logic [NB_BLOCK-1:0] ghash_len_block(
        input logic [NB_LEN-1:0] len_aad,
        input logic [NB_LEN-1:0] len_text
    );
        return {len_aad, len_text};
    endfunction

endpackage

// File: rtl/ghash_block_packer.sv
// Pairs serial 128-bit GCM blocks into 256-bit GHASH words and appends len(A)||len(C).
// One cycle from completing transfer to word; no downstream backpressure, ready only in COLLECT.
module ghash_block_packer
    import ghash_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_LEN-1:0]   i_len_aad,
    input  logic [NB_LEN-1:0]   i_len_text,
    input  logic [NB_BLOCK-1:0] i_block,
    input  logic                i_block_valid,
    input  logic                i_block_last,
    output logic                o_block_ready,
    output logic [NB_DATA-1:0]  o_data_x,
    output logic [N_BLOCKS-1:0] o_skip_bus,
    output logic                o_valid,
    output logic                o_sop,
    output logic                o_eop,
    output logic                o_busy
);

    state_t                state;
    logic [NB_LEN-1:0]     len_aad;
    logic [NB_LEN-1:0]     len_text;
    logic [NB_BLOCK-1:0]   held;
    logic                  half;
    logic                  first_word;
    logic                  xfer;

    // o_block_ready is registered as "next state is COLLECT", so it tracks the state exactly.
    assign xfer = i_block_valid & o_block_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            len_aad       <= '0;
            len_text      <= '0;
            held          <= '0;
            half          <= 1'b0;
            first_word    <= 1'b0;
            o_block_ready <= 1'b0;
            o_data_x      <= '0;
            o_skip_bus    <= '0;
            o_valid       <= 1'b0;
            o_sop         <= 1'b0;
            o_eop         <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            case (state)
                IDLE: begin
                    o_busy <= i_start;
                    if (i_start) begin
                        len_aad    <= i_len_aad;
                        len_text   <= i_len_text;
                        first_word <= 1'b1;
                        half       <= 1'b0;
                        held       <= '0;
                        if (i_len_aad == '0 && i_len_text == '0) begin
                            state         <= LENGTH;
                            o_block_ready <= 1'b0;
                        end else begin
                            state         <= COLLECT;
                            o_block_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        if (!half) begin
                            held <= i_block;
                            half <= 1'b1;
                        end else begin
                            o_data_x   <= {i_block, held};
                            o_skip_bus <= SKIP_NONE;
                            o_valid    <= 1'b1;
                            o_sop      <= first_word;
                            first_word <= 1'b0;
                            half       <= 1'b0;
                            held       <= '0;
                        end
                        if (i_block_last) begin
                            state         <= LENGTH;
                            o_block_ready <= 1'b0;
                        end
                    end
                end
                LENGTH: begin
                    // An odd block count shares its word with the length block.
                    if (half) begin
                        o_data_x   <= {ghash_len_block(len_aad, len_text), held};
                        o_skip_bus <= SKIP_NONE;
                    end else begin
                        o_data_x   <= {{NB_BLOCK{1'b0}}, ghash_len_block(len_aad, len_text)};
                        o_skip_bus <= SKIP_LANE1;
                    end
                    o_valid       <= 1'b1;
                    o_sop         <= first_word;
                    o_eop         <= 1'b1;
                    first_word    <= 1'b0;
                    half          <= 1'b0;
                    held          <= '0;
                    o_block_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    o_block_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ghash_block_packer.md
Name: ghash_block_packer

Overview:
- Source-side feeder for the 2-block-per-cycle GHASH core.
- Accepts a serial stream of 128-bit GCM blocks (AAD first, then ciphertext) over a valid/ready handshake, pairs them into 256-bit words and appends the final length block len(A)||len(C).
- Drives the core's i_data_x / i_skip_bus / i_sop / i_valid inputs and flags the last word so downstream logic knows when the core output is final.

Parameters:
- NB_BLOCK, 128, bits per GCM block.
- N_BLOCKS, 2, blocks per output word; the design supports 2 only.
- NB_DATA, N_BLOCKS*NB_BLOCK, output word width.
- NB_LEN, 64, width of each length field.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  starts a message; lengths sampled on this cycle.
- i_len_aad  in  NB_LEN  AAD length in bits.
- i_len_text  in  NB_LEN  ciphertext length in bits.
- i_block  in  NB_BLOCK  input block, already zero-padded.
- i_block_valid  in  1  input block valid.
- i_block_last  in  1  marks the last data block of the message.
- o_block_ready  out  1  packer can accept i_block this cycle.
- o_data_x  out  NB_DATA  packed word; earlier block in [0+:NB_BLOCK].
- o_skip_bus  out  N_BLOCKS  lane empty flags; bit k=1 means lane k is zero and carries no block.
- o_valid  out  1  o_data_x valid (one-cycle qualifier per word).
- o_sop  out  1  first word of the message.
- o_eop  out  1  word carrying the length block.
- o_busy  out  1  message in progress.

Behaviour:
- Reset is synchronous, active-high on i_reset, clocked by i_clock. It has priority over everything and may be asserted mid-message; the in-flight message is dropped with no partial word emitted.
- Reset values: o_valid=0, o_sop=0, o_eop=0, o_data_x=0, o_skip_bus=0, o_block_ready=0, o_busy=0. FSM goes to IDLE and the holding register is cleared.
- FSM states: IDLE, COLLECT, LENGTH.
- IDLE:
  - o_block_ready=0.
  - On i_start, register both lengths and set first_word=1.
  - If i_len_aad==0 and i_len_text==0, go to LENGTH; otherwise go to COLLECT.
- COLLECT:
  - o_block_ready=1. A transfer occurs when i_block_valid & o_block_ready.
  - One holding register plus a flag `half`.
  - Transfer with half=0: store the block and set half=1.
  - Transfer with half=1: emit {i_block, held} next cycle, skip=2'b00, clear half.
  - A transfer with i_block_last=1 moves the FSM to LENGTH after the block is handled.
- LENGTH:
  - o_block_ready=0. Lasts exactly one cycle. Length block L = {len_aad, len_text}, with len_aad in [NB_BLOCK-1:NB_LEN].
  - If half=1, emit {L, held} with skip=2'b00.
  - If half=0, emit {0, L} with skip=2'b10.
  - Set o_eop=1, then return to IDLE.
- Output timing:
  - All outputs are registered; a word appears exactly 1 cycle after the transfer or LENGTH cycle that completes it.
  - o_valid is high only on that cycle. There is no downstream backpressure.
- o_sop is asserted on the first word emitted after i_start, then cleared. Words can have sop=eop=1 (empty message, or a single data block).
- o_busy=1 from the cycle after i_start until the cycle the eop word is presented, inclusive.
- Boundary conditions:
  - i_start outside IDLE is ignored, and lengths are not resampled.
  - i_block_valid in IDLE or LENGTH is not accepted.
  - i_block_last must accompany a valid transfer; i_block_last without i_block_valid is ignored.
  - Back-to-back messages: i_start may be asserted in the cycle after LENGTH. The minimum gap between eop words of consecutive messages is 2 cycles plus data.
  - Block/length consistency is not checked; a block count mismatching the lengths is the caller's problem.
  - Lane 1 of a half-filled word is always all zeros.

Decomposition:
- Shared package `ghash_pkg`:
  - NB_BLOCK, N_BLOCKS, NB_LEN constants.
  - FSM state encoding (IDLE=2'd0, COLLECT=2'd1, LENGTH=2'd2).
  - Skip encodings SKIP_NONE=2'b00 and SKIP_LANE1=2'b10.
- Single module, no sub-module. An optional `ghash_len_block` function belongs in the package for reuse by the decrypt path.

Test Plan:
- Empty message: i_start, len_aad=0, len_text=0 -> one word at start+2, o_data_x=256'h0, skip=2'b10, sop=eop=valid=1.
- One AAD block plus one text block:
  - Stimulus: i_start with len_aad=128, len_text=128; send block A=128'hA5..A5, then C=128'h3C..3C with last=1.
  - Response: word1={C,A}, skip=00, sop=1, eop=0; word2={0, {64'd128,64'd128}}, skip=2'b10, eop=1.
- Three blocks B0,B1,B2 (last on B2), len_text=384 -> word1={B1,B0} with sop=1; word2={L,B2} with skip=00, eop=1; exactly 2 o_valid pulses.
- Input gaps: drive i_block_valid with 1-0-0-1 spacing -> output word appears only 1 cycle after the second transfer; o_block_ready stays 1 throughout COLLECT.
- Reset mid-message: assert i_reset after B0 accepted -> all outputs 0 next cycle, no word emitted; a new i_start with 2 blocks yields a clean sop word with no B0 contamination.
- i_start pulsed during COLLECT with different lengths -> ignored; the eop word carries the originally sampled lengths.
